// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
// Contents:
//   ALUOP_*  : 3-bit AluOp codes presented by the CPU
//   SOP_*    : 2-bit Operation encodings understood by the 1-bit slice
//   state_t  : sequencer state encoding
//   decode_t : decoded view of an AluOp
package alu_pkg;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_XOR = 3'b011;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  localparam logic [1:0] SOP_AND = 2'b00;
  localparam logic [1:0] SOP_OR  = 2'b01;
  localparam logic [1:0] SOP_ADD = 2'b10;
  localparam logic [1:0] SOP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] slice_op;
    logic       binvert;
    logic       is_arith;
    logic       is_slt;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational AluOp decoder.
// Ports:
//   AluOp : 3-bit operation code from the CPU
//   dec   : slice Operation, BInvert, arithmetic/SLT qualifiers, illegal flag
// Undefined codes fall back to AND with the illegal flag raised.
import alu_pkg::*;

module alu_op_decode (
  input  logic [2:0] AluOp,
  output decode_t    dec
);

  always_comb begin
    dec.slice_op = SOP_AND;
    dec.binvert  = 1'b0;
    dec.is_arith = 1'b0;
    dec.is_slt   = 1'b0;
    dec.illegal  = 1'b0;
    case (AluOp)
      ALUOP_AND: dec.slice_op = SOP_AND;
      ALUOP_OR:  dec.slice_op = SOP_OR;
      ALUOP_XOR: dec.slice_op = SOP_XOR;
      ALUOP_ADD: begin
        dec.slice_op = SOP_ADD;
        dec.is_arith = 1'b1;
      end
      ALUOP_SUB: begin
        dec.slice_op = SOP_ADD;
        dec.binvert  = 1'b1;
        dec.is_arith = 1'b1;
      end
      ALUOP_SLT: begin
        dec.slice_op = SOP_ADD;
        dec.binvert  = 1'b1;
        dec.is_arith = 1'b1;
        dec.is_slt   = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Bit-serial driver for an external 1-bit ALU slice.
// Accepts a WIDTH-bit operation, streams one operand bit pair per cycle
// (LSB first) into the slice, chains carry through a register and
// reassembles the result plus flags.
// Ports:
//   Clock, Reset               : clock, synchronous active-high reset
//   Start, AluOp, OpA, OpB     : request (sampled only while Ready)
//   SliceA/B/CIN/BInvert/Operation : drive to the slice (0 outside RUN)
//   SliceResult, SliceCOUT     : combinational returns from the slice
//   Ready, Done                : idle indicator, one-cycle completion pulse
//   Result, Zero, CarryOut, Overflow, Illegal : held until replaced
//
// state  | meaning
// IDLE   | Ready=1, waiting for Start
// RUN    | one slice step per cycle, WIDTH cycles
// FINISH | Done pulse, Result/flags valid
import alu_pkg::*;

module alu_serial_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             SliceA,
  output logic             SliceB,
  output logic             SliceCIN,
  output logic             SliceBInvert,
  output logic [1:0]       SliceOperation,
  input  logic             SliceResult,
  input  logic             SliceCOUT,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Illegal
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  decode_t          dec_in, dec_q;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [WIDTH-1:0] r_full, r_final;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             run, accept, last_step, msb_ovf;

  alu_op_decode u_decode (
    .AluOp (AluOp),
    .dec   (dec_in)
  );

  assign run       = (state == ST_RUN);
  assign accept    = (state == ST_IDLE) && Start;
  assign last_step = run && (cnt == LAST_BIT);

  // Final result as it will look once the MSB step is shifted in; SLT
  // replaces it with the signed-less-than bit (sign corrected by overflow).
  always_comb begin
    r_full  = {SliceResult, r_sh[WIDTH-1:1]};
    msb_ovf = carry ^ SliceCOUT;
    r_final = r_full;
    if (dec_q.is_slt) begin
      r_final = {{(WIDTH-1){1'b0}}, SliceResult ^ msb_ovf};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (Start) state_nxt = ST_RUN;
      ST_RUN:    if (cnt == LAST_BIT) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Slice drive comes only from registers, gated by the registered state,
  // so nothing on Start reaches the slice combinationally.
  always_comb begin
    Ready          = (state == ST_IDLE);
    Done           = (state == ST_FINISH);
    SliceA         = 1'b0;
    SliceB         = 1'b0;
    SliceCIN       = 1'b0;
    SliceBInvert   = 1'b0;
    SliceOperation = SOP_AND;
    if (run) begin
      SliceA         = a_sh[0];
      SliceB         = b_sh[0];
      SliceCIN       = carry;
      SliceBInvert   = dec_q.binvert;
      SliceOperation = dec_q.slice_op;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      dec_q    <= '0;
      Result   <= '0;
      Zero     <= 1'b0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Illegal  <= 1'b0;
    end else if (accept) begin
      a_sh  <= OpA;
      b_sh  <= OpB;
      r_sh  <= '0;
      carry <= dec_in.binvert;
      cnt   <= '0;
      dec_q <= dec_in;
    end else if (run) begin
      r_sh  <= r_full;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= SliceCOUT;
      cnt   <= cnt + CW'(1);
      if (last_step) begin
        Result   <= r_final;
        Zero     <= (r_final == '0);
        CarryOut <= SliceCOUT;
        Overflow <= dec_q.is_arith & msb_ovf;
        Illegal  <= dec_q.illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Bench for alu_serial_sequencer with a behavioural 1-bit slice and a
// word-level arithmetic reference model.
module tb_alu_serial_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  AluOp = 3'b000;
  logic [15:0] OpA = '0, OpB = '0;
  logic        SliceA, SliceB, SliceCIN, SliceBInvert;
  logic [1:0]  SliceOperation;
  logic        SliceResult, SliceCOUT;
  logic        Ready, Done, Zero, CarryOut, Overflow, Illegal;
  logic [15:0] Result;

  int n_chk = 0;
  int n_err = 0;

  alu_serial_sequencer #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .AluOp(AluOp),
    .OpA(OpA), .OpB(OpB),
    .SliceA(SliceA), .SliceB(SliceB), .SliceCIN(SliceCIN),
    .SliceBInvert(SliceBInvert), .SliceOperation(SliceOperation),
    .SliceResult(SliceResult), .SliceCOUT(SliceCOUT),
    .Ready(Ready), .Done(Done), .Result(Result), .Zero(Zero),
    .CarryOut(CarryOut), .Overflow(Overflow), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  // 1-bit ALU slice: full-adder carry always produced on COUT.
  logic b_eff;
  always_comb begin
    b_eff     = SliceB ^ SliceBInvert;
    SliceCOUT = (SliceA & b_eff) | (SliceA & SliceCIN) | (b_eff & SliceCIN);
    case (SliceOperation)
      2'b00:   SliceResult = SliceA & b_eff;
      2'b01:   SliceResult = SliceA | b_eff;
      2'b10:   SliceResult = SliceA ^ b_eff ^ SliceCIN;
      default: SliceResult = SliceA ^ b_eff;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Word-level reference: what the op means, independent of serialisation.
  task automatic ref_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic cout, output logic ov,
                        output logic ill, output logic binv, output logic [1:0] sop);
    logic [16:0] s;
    ov = 1'b0; ill = 1'b0; binv = 1'b0;
    s  = {1'b0, a} + {1'b0, b};
    cout = s[16];
    case (op)
      3'b000: begin res = a & b; sop = 2'b00; end
      3'b001: begin res = a | b; sop = 2'b01; end
      3'b011: begin res = a ^ b; sop = 2'b11; end
      3'b010: begin
        res = s[15:0]; sop = 2'b10;
        ov  = (a[15] == b[15]) && (res[15] != a[15]);
      end
      3'b110, 3'b111: begin
        s    = {1'b0, a} + {1'b0, ~b} + 17'd1;
        cout = s[16]; sop = 2'b10; binv = 1'b1;
        ov   = (a[15] != b[15]) && (s[15] != a[15]);
        if (op == 3'b111) res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        else              res = s[15:0];
      end
      default: begin res = a & b; sop = 2'b00; ill = 1'b1; end
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after Done.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input bit inject);
    logic [15:0] e_res;
    logic e_cout, e_ov, e_ill, e_binv;
    logic [1:0] e_sop;
    int cycles;
    ref_op(op, a, b, e_res, e_cout, e_ov, e_ill, e_binv, e_sop);
    chk({nm, " ready_before"}, Ready, 1'b1);
    Start = 1'b1; AluOp = op; OpA = a; OpB = b;
    @(negedge Clock);
    Start = 1'b0;
    cycles = 1;
    chk({nm, " ready_drop"}, Ready, 1'b0);
    chk({nm, " binvert"}, SliceBInvert, e_binv);
    chk({nm, " first_cin"}, SliceCIN, e_binv);
    chk({nm, " slice_op"}, SliceOperation, e_sop);
    while (!Done && cycles < 40) begin
      if (inject && (cycles == 3 || cycles == 9)) begin
        Start = 1'b1; AluOp = 3'b010;
        OpA = 16'($urandom); OpB = 16'($urandom);
      end
      @(negedge Clock);
      cycles++;
      Start = 1'b0;
    end
    chk({nm, " latency"}, cycles, 17);
    chk({nm, " result"}, Result, e_res);
    chk({nm, " zero"}, Zero, (e_res == 16'd0));
    chk({nm, " carry"}, CarryOut, e_cout);
    chk({nm, " overflow"}, Overflow, e_ov);
    chk({nm, " illegal"}, Illegal, e_ill);
    @(negedge Clock);
    chk({nm, " done_single"}, Done, 1'b0);
    chk({nm, " ready_after"}, Ready, 1'b1);
    chk({nm, " result_held"}, Result, e_res);
  endtask

  logic [2:0] ops [8] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100, 3'b101};

  initial begin
    int dcount;
    logic [15:0] ra, rb;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst ready", Ready, 1'b1);
    chk("rst done", Done, 1'b0);
    chk("rst result", Result, 16'd0);
    chk("rst flags", {Zero, CarryOut, Overflow, Illegal}, 4'b0000);
    chk("rst slice", {SliceA, SliceB, SliceCIN, SliceBInvert, SliceOperation}, 6'd0);

    run_op("add_ovf", 3'b010, 16'h7FFF, 16'h0001, 1'b0);
    run_op("sub_eq",  3'b110, 16'h0005, 16'h0005, 1'b0);
    run_op("slt_neg", 3'b111, 16'hFFFF, 16'h0001, 1'b0);
    run_op("slt_ovf", 3'b111, 16'h8000, 16'h7FFF, 1'b0);
    run_op("slt_gt",  3'b111, 16'h0003, 16'h0002, 1'b0);
    run_op("xor",     3'b011, 16'hA5A5, 16'h0FF0, 1'b0);
    run_op("and",     3'b000, 16'hF0F0, 16'h3C3C, 1'b0);
    run_op("or",      3'b001, 16'hF0F0, 16'h3C3C, 1'b0);
    run_op("illegal", 3'b100, 16'hF0F0, 16'h3C3C, 1'b0);
    run_op("inject",  3'b010, 16'h1234, 16'h4321, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? ra : 16'($urandom);
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 7)], ra, rb, (i % 7 == 3));
    end

    // Abort mid-RUN: Result from the previous op is nonzero here.
    run_op("pre_rst", 3'b001, 16'h00F0, 16'h0F00, 1'b0);
    Start = 1'b1; AluOp = 3'b010; OpA = 16'h1111; OpB = 16'h2222;
    @(negedge Clock);
    Start = 1'b0;
    repeat (8) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort ready", Ready, 1'b1);
    chk("abort result", Result, 16'd0);
    chk("abort done", Done, 1'b0);
    chk("abort flags", {Zero, CarryOut, Overflow, Illegal}, 4'b0000);
    dcount = 0;
    repeat (20) begin
      @(negedge Clock);
      if (Done) dcount++;
    end
    chk("abort no_done", dcount, 0);
    run_op("post_rst", 3'b010, 16'h0001, 16'h0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
Bit-serial driver for the 1-bit ALU slice. It is the control/operand side of the slice interface: it accepts a 16-bit operation, feeds one bit pair per cycle into the slice, chains carry through a register, and reassembles the 16-bit result with flags. It lets the CPU execute ALU ops on a single slice, as an area-reduced datapath option and as a slice-level self-check engine.

Parameters:
WIDTH, 16, operand/result width; number of serial bit steps.

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only when Ready=1
AluOp  input  3  operation: 000 AND, 001 OR, 010 ADD, 011 XOR, 110 SUB, 111 SLT; others illegal
OpA  input  WIDTH  operand A, latched on accepted Start
OpB  input  WIDTH  operand B, latched on accepted Start
SliceA  output  1  to slice A
SliceB  output  1  to slice B
SliceCIN  output  1  to slice CIN
SliceBInvert  output  1  to slice BInvert
SliceOperation  output  2  to slice Operation (00 AND, 01 OR, 10 ADD, 11 XOR)
SliceResult  input  1  from slice Result (combinational, same cycle)
SliceCOUT  input  1  from slice COUT (combinational, same cycle)
Ready  output  1  idle, Start will be accepted
Done  output  1  one-cycle pulse, Result/flags valid
Result  output  WIDTH  assembled result, held until next accepted Start
Zero  output  1  Result == 0
CarryOut  output  1  final COUT of MSB step
Overflow  output  1  signed overflow (ADD/SUB/SLT only, else 0)
Illegal  output  1  AluOp was undefined (valid with Done)

Behaviour:
- States: IDLE, RUN, FINISH. Reset -> IDLE; all outputs 0 except Ready=1; internal regs 0.
- Reset is synchronous and takes priority over everything; Reset mid-RUN aborts and discards the op with no Done. Result and flags return to 0.
- IDLE: Ready=1. On Start=1: latch OpA/OpB into shift registers, decode AluOp, set carry reg = BInvert (1 for SUB/SLT, else 0), bit counter=0, go RUN. Ready drops the next cycle.
- Decode: AND/OR/ADD/XOR map to Operation 00/01/10/11 with BInvert=0. SUB and SLT map to Operation 10 with BInvert=1. Illegal ops execute as AND with Illegal=1.
- RUN, one bit per cycle, LSB first: SliceA=A_sh[0], SliceB=B_sh[0], SliceCIN=carry reg, and Operation/BInvert are held constant. At the clock edge: result shift reg shifts right with SliceResult inserted at MSB; A_sh and B_sh shift right; carry reg<=SliceCOUT; counter++.
- On the MSB step (counter==WIDTH-1), capture CarryOut=SliceCOUT, Overflow=SliceCIN^SliceCOUT (arith ops), and sign=SliceResult, then go FINISH.
- Start during RUN/FINISH is ignored and not queued.
- FINISH (1 cycle): Result = shift reg, except SLT, where Result = {WIDTH-1 zeros, sign^Overflow}. Zero computed on the final Result. Done=1 for exactly this cycle, then IDLE.
- Latency: Start accepted at edge 0, Done high in cycle WIDTH+1 (17 for WIDTH=16). Back-to-back throughput is 1 op per WIDTH+2 cycles.
- Slice outputs are registered-sourced (no comb path from Start to Slice*). In IDLE/FINISH, Slice* = 0.
- Overflow=0 and CarryOut is the raw last COUT for logic ops.

Decomposition:
- Shared package alu_pkg: AluOp code constants, slice Operation encodings, state enum (IDLE/RUN/FINISH).
- Sub-module alu_op_decode (combinational): AluOp -> {SliceOperation, BInvert, is_arith, is_slt, illegal}.
- The ALU slice itself is instantiated outside this block (bench and CPU wrapper connect it).

Test Plan:
- ADD OpA=0x7FFF, OpB=0x0001 -> Result=0x8000, Overflow=1, CarryOut=0, Zero=0, Done exactly 17 cycles after Start.
- SUB OpA=0x0005, OpB=0x0005 -> Result=0x0000, Zero=1, CarryOut=1, Overflow=0. During RUN, check SliceBInvert=1 and first SliceCIN=1.
- SLT OpA=0xFFFF, OpB=0x0001 -> Result=0x0001. SLT OpA=0x8000, OpB=0x7FFF -> Result=0x0001 (overflow path). SLT 0x0003, 0x0002 -> 0x0000.
- XOR 0xA5A5 ^ 0x0FF0 -> 0xAA55. AND 0xF0F0 & 0x3C3C -> 0x3030. OR -> 0xFCFC. AluOp=100 -> Illegal=1 with AND result.
- Start pulsed at cycles 3 and 9 of a RUN with different operands -> ignored, first op's Result unchanged, single Done.
- Reset asserted at RUN bit 8 -> next cycle Ready=1, Result=0, no Done. A new ADD 0x0001+0x0001 then completes with 0x0002.
